// File: rtl/ppu_line_scheduler_if.sv
//------------------------------------------------------------------------------
// Module   : ppu_line_scheduler_if
// Brief    : PPU/VGA timing inputs and line-RAM control outputs of the scheduler.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface ppu_line_scheduler_if;
   logic [7:0] LY;
   logic [9:0] HCount;
   logic [9:0] VCount;
   logic       clrOverrun;
   logic       wrEn;
   logic [7:0] ramAddr;
   logic       busy;
   logic       overrun;
   logic       frameDone;

   modport master (
      output LY, HCount, VCount, clrOverrun,
      input  wrEn, ramAddr, busy, overrun, frameDone
   );

   modport slave (
      input  LY, HCount, VCount, clrOverrun,
      output wrEn, ramAddr, busy, overrun, frameDone
   );
endinterface

`default_nettype wire

// File: rtl/ppu_line_scheduler.sv
//------------------------------------------------------------------------------
// Module   : ppu_line_scheduler
// Brief    : Arbitrates a single-ported line RAM between display reads and PPU line writes.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ppu_line_scheduler #(
   parameter int H_ACTIVE = 160,
   parameter int V_ACTIVE = 144,
   parameter int H_MAX    = 799
) (
   input  wire                  pixelClk,
   input  wire                  rstN,
   ppu_line_scheduler_if.slave  bus
);

   localparam logic [9:0] c_H_ACTIVE  = H_ACTIVE[9:0];
   localparam logic [9:0] c_V_ACTIVE  = V_ACTIVE[9:0];
   localparam logic [9:0] c_H_MAX     = H_MAX[9:0];
   localparam logic [7:0] c_LAST_LINE = 8'(V_ACTIVE - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PEND  = 2'd1,
      WRITE = 2'd2
   } state_t;

   state_t     r_state;
   state_t     w_nextState;
   logic [7:0] r_lastLY;
   logic [7:0] r_wrLine;
   logic       r_overrun;
   logic       r_frameDone;

   logic       w_readWin;
   logic       w_change;
   logic       w_lyValid;
   logic       w_grant;
   logic       w_capture;

   assign w_readWin = (bus.HCount < c_H_ACTIVE) && (bus.VCount < c_V_ACTIVE);
   assign w_change  = (bus.LY != r_lastLY);
   assign w_lyValid = ({2'b00, bus.LY} < c_V_ACTIVE);
   assign w_grant   = !w_readWin && (bus.HCount != c_H_MAX);
   // Capture of a new line is possible in IDLE and (as a supersede) in PEND.
   assign w_capture = w_change && w_lyValid && (r_state == IDLE || r_state == PEND);

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE:    if (w_capture) w_nextState = PEND;
         PEND:    if (!w_capture && w_grant) w_nextState = WRITE;
         WRITE:   w_nextState = IDLE;
         default: w_nextState = IDLE;
      endcase
   end

   always_ff @(posedge pixelClk or negedge rstN) begin
      if (!rstN) begin
         r_state     <= IDLE;
         r_lastLY    <= 8'd0;
         r_wrLine    <= 8'd0;
         r_overrun   <= 1'b0;
         r_frameDone <= 1'b0;
      end else begin
         r_state     <= w_nextState;
         r_frameDone <= (r_state == WRITE) && (r_wrLine == c_LAST_LINE);
         if (w_capture) begin
            r_wrLine <= bus.LY;
            r_lastLY <= bus.LY;
         end else if (r_state == IDLE && w_change) begin
            r_lastLY <= bus.LY;
         end
         // Supersede wins over a simultaneous clear.
         if (w_capture && r_state == PEND) begin
            r_overrun <= 1'b1;
         end else if (bus.clrOverrun) begin
            r_overrun <= 1'b0;
         end
      end
   end

   assign bus.wrEn      = (r_state == WRITE);
   assign bus.busy      = (r_state != IDLE);
   assign bus.overrun   = r_overrun;
   assign bus.frameDone = r_frameDone;
   assign bus.ramAddr   = (r_state == WRITE) ? r_wrLine :
                          w_readWin          ? bus.VCount[7:0] : 8'd0;

endmodule

`default_nettype wire

// File: doc/ppu_line_scheduler.md
PPU_LINE_SCHEDULER -- requirements
Module: ppu_line_scheduler

Interface
REQ-001 Parameter H_ACTIVE, default 160, meaning displayed pixels per line (read window width).
REQ-002 Parameter V_ACTIVE, default 144, meaning displayed lines per frame (read window height; LY values at or above it are not captured).
REQ-003 Parameter H_MAX, default 799, meaning last HCount value of a VGA line.
REQ-004 pixelClk  in  1  sole clock; all logic on its rising edge.
REQ-005 rstN  in  1  reset, asynchronous, active-low.
REQ-006 LY  in  8  current PPU line index, synchronous to pixelClk.
REQ-007 HCount  in  10  VGA horizontal counter, 0..H_MAX.
REQ-008 VCount  in  10  VGA vertical counter.
REQ-009 clrOverrun  in  1  synchronous clear of the overrun flag.
REQ-010 wrEn  out  1  write strobe to all four bitplane line RAMs.
REQ-011 ramAddr  out  8  shared line-RAM address (write line or read line).
REQ-012 busy  out  1  high while a capture is pending or being written.
REQ-013 overrun  out  1  sticky; a pending capture was superseded before it was written.
REQ-014 frameDone  out  1  one-cycle pulse after line V_ACTIVE-1 is written.

Function
REQ-015 The line RAM is single-ported; the block SHALL arbitrate it between display reads and PPU line writes, with reads having absolute priority.
REQ-016 readWin SHALL be high when HCount < H_ACTIVE and VCount < V_ACTIVE; ramAddr SHALL equal VCount[7:0] whenever readWin is high and state is not WRITE.
REQ-017 FSM states SHALL be IDLE, PEND and WRITE; reset state is IDLE.
REQ-018 Register lastLY SHALL hold the last accepted LY; a change is detected when LY != lastLY.
REQ-019 IDLE: on change with LY < V_ACTIVE, SHALL latch wrLine <= LY, lastLY <= LY and go to PEND; on change with LY >= V_ACTIVE, SHALL update lastLY only and stay in IDLE.
REQ-020 PEND: grant SHALL be (not readWin) and HCount != H_MAX; on grant go to WRITE next cycle; otherwise stay in PEND.
REQ-021 PEND: on a new change with LY < V_ACTIVE, SHALL replace wrLine and lastLY with LY and set overrun; this takes precedence over grant in the same cycle (the write is deferred, FSM stays in PEND).
REQ-022 WRITE: SHALL last exactly one cycle with wrEn = 1 and ramAddr = wrLine, then return to IDLE; LY changes in this cycle are not acted upon and are detected in IDLE on the next cycle.
REQ-023 Latency: a change first visible in IDLE at cycle t with grant true at t+1 SHALL give wrEn = 1 at cycle t+2.
REQ-024 wrEn SHALL never be high in a cycle where readWin is high.
REQ-025 busy SHALL be high in PEND and WRITE, low in IDLE.
REQ-026 frameDone SHALL pulse for one cycle in the cycle after a WRITE of wrLine = V_ACTIVE-1.
REQ-027 overrun SHALL be cleared by clrOverrun; a set and a clear in the same cycle SHALL leave overrun = 1.
REQ-028 When not in WRITE and readWin is low, ramAddr SHALL be 0.

Reset
REQ-029 While rstN = 0: state = IDLE, lastLY = 0, wrLine = 0, wrEn = 0, busy = 0, overrun = 0, frameDone = 0, ramAddr per REQ-016/REQ-028.
REQ-030 Reset asserted mid-PEND or mid-WRITE SHALL abort the capture immediately with no wrEn pulse; after release, LY != 0 SHALL be detected as a new change.

Verification
REQ-031 HCount = 200, VCount = 50, LY 0 -> 5 -> busy at next cycle, wrEn = 1 with ramAddr = 5 exactly two cycles after the change, then busy = 0.
REQ-032 LY 7 -> 8 with HCount = 10, VCount = 20 -> stays in PEND with no wrEn until HCount = 160; wrEn = 1 and ramAddr = 8 one cycle later.
REQ-033 PEND entered with HCount = 799 and VCount = 200 -> no grant at 799; grant at HCount = 0, wrEn one cycle later.
REQ-034 LY 3 -> 4 -> 5 while blocked by readWin -> overrun = 1; a single write with ramAddr = 5; clrOverrun -> overrun = 0.
REQ-035 LY 143 -> 144 -> write of line 143 has already produced frameDone; the change to 144 causes no wrEn, and lastLY = 144.
REQ-036 rstN pulsed low while in PEND (LY = 9) -> no wrEn; after release, LY = 9 is recaptured and written once.
